// File: rtl/thermometer_pkg.sv
// Shared types and helpers for the thermometer mask unit: request mode encoding,
// mask-width helper and the population count computed from the indices alone.
package thermometer_pkg;

    typedef enum logic [1:0] {
        THERM_LO = 2'd0,
        THERM_HI = 2'd1,
        ONEHOT   = 2'd2,
        RANGE    = 2'd3
    } mode_e;

    localparam int MaxInBitWidth = 16;

    typedef logic [MaxInBitWidth:0] count_t;

    function automatic int out_bit_width(input int in_bit_width);
        return 1 << in_bit_width;
    endfunction

    // Count of set bits, derived arithmetically so it never depends on the mask path.
    function automatic count_t thermo_count(input mode_e                    mode,
                                            input logic [MaxInBitWidth-1:0] a,
                                            input logic [MaxInBitWidth-1:0] b,
                                            input int                       in_bit_width);
        count_t wa;
        count_t wb;
        count_t wn;
        count_t one;
        count_t r;
        wa  = {1'b0, a};
        wb  = {1'b0, b};
        one = count_t'(1);
        wn  = one << in_bit_width;
        case (mode)
            THERM_LO: r = wa + one;
            THERM_HI: r = wn - wa;
            ONEHOT:   r = one;
            default:  r = (a <= b) ? (wb - wa + one) : (wn - (wa - wb) + one);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/thermometer_mask_unit_ge_decode.sv
// Combinational "k >= idx" thermometer decoder: bit k of ge is set when k >= idx.
module thermometer_ge_decode
    import thermometer_pkg::*;
#(
    parameter int InBitWidth  = 5,
    parameter int OutBitWidth = out_bit_width(InBitWidth)
) (
    input  logic [InBitWidth-1:0]  idx,
    output logic [OutBitWidth-1:0] ge
);

    always_comb begin
        ge = '0;
        for (int k = 0; k < OutBitWidth; k++) begin
            ge[k] = (InBitWidth'(k) >= idx);
        end
    end

endmodule

// File: rtl/thermometer_mask_unit.sv
// Two-stage valid/ready mask generator (low/high thermometer, one-hot, wrapping range).
// Define THERM_MASK_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module thermometer_mask_unit
    import thermometer_pkg::*;
#(
    parameter int InBitWidth  = 5,
    parameter int OutBitWidth = out_bit_width(InBitWidth)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  mode_e                  in_mode,
    input  logic [InBitWidth-1:0]  in_lo,
    input  logic [InBitWidth-1:0]  in_hi,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OutBitWidth-1:0] out_mask,
    output logic [InBitWidth:0]    out_ones
);

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   s1_advance;
    logic                   s1_open;
    mode_e                  s1_mode;
    logic                   s1_wrap;
    logic [OutBitWidth-1:0] s1_ge;
    logic [OutBitWidth-1:0] s1_le;
    logic [InBitWidth:0]    s1_ones;

    logic                   src_valid;
    mode_e                  src_mode;
    logic [InBitWidth-1:0]  src_lo;
    logic [InBitWidth-1:0]  src_hi;

    assign s1_advance = !s2_valid || out_ready;
    assign s1_open    = !s1_valid || s1_advance;
    assign out_valid  = s2_valid;

`ifdef THERM_MASK_SKID_EN
    logic                  skid_empty;
    mode_e                 skid_mode;
    logic [InBitWidth-1:0] skid_lo;
    logic [InBitWidth-1:0] skid_hi;

    // A parked request always drains into stage 1 before any new one is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_empty <= 1'b1;
        end else if (!skid_empty) begin
            if (s1_open) skid_empty <= 1'b1;
        end else if (in_valid && !s1_open) begin
            skid_empty <= 1'b0;
            skid_mode  <= in_mode;
            skid_lo    <= in_lo;
            skid_hi    <= in_hi;
        end
    end

    assign in_ready  = skid_empty;
    assign src_valid = !skid_empty || in_valid;
    assign src_mode  = skid_empty ? in_mode : skid_mode;
    assign src_lo    = skid_empty ? in_lo   : skid_lo;
    assign src_hi    = skid_empty ? in_hi   : skid_hi;
`else
    assign in_ready  = rst_n && s1_open;
    assign src_valid = in_valid;
    assign src_mode  = in_mode;
    assign src_lo    = in_lo;
    assign src_hi    = in_hi;
`endif

    logic [InBitWidth-1:0]  b_eff;
    logic [InBitWidth-1:0]  b_inc;
    logic [OutBitWidth-1:0] ge_a;
    logic [OutBitWidth-1:0] ge_binc;
    logic [OutBitWidth-1:0] le_b;
    count_t                 count_full;
    logic                   count_unused;

    // Only RANGE uses in_hi; the other modes build le from a itself.
    assign b_eff = (src_mode == RANGE) ? src_hi : src_lo;
    assign b_inc = b_eff + InBitWidth'(1);

    thermometer_ge_decode #(.InBitWidth(InBitWidth), .OutBitWidth(OutBitWidth)) u_ge_a (
        .idx (src_lo),
        .ge  (ge_a)
    );

    thermometer_ge_decode #(.InBitWidth(InBitWidth), .OutBitWidth(OutBitWidth)) u_ge_b (
        .idx (b_inc),
        .ge  (ge_binc)
    );

    // b+1 wraps to zero at the top index, so that case is forced to all-ones.
    assign le_b = (&b_eff) ? '1 : ~ge_binc;

    assign count_full   = thermo_count(src_mode, MaxInBitWidth'(src_lo),
                                       MaxInBitWidth'(src_hi), InBitWidth);
    assign count_unused = ^count_full[MaxInBitWidth:InBitWidth+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_open) begin
            s1_valid <= src_valid;
            if (src_valid) begin
                s1_mode <= src_mode;
                s1_wrap <= (src_lo > src_hi);
                s1_ge   <= ge_a;
                s1_le   <= le_b;
                s1_ones <= count_full[InBitWidth:0];
            end
        end
    end

    logic [OutBitWidth-1:0] mask_d;

    always_comb begin
        case (s1_mode)
            THERM_LO: mask_d = s1_le;
            THERM_HI: mask_d = s1_ge;
            ONEHOT:   mask_d = s1_ge & s1_le;
            default:  mask_d = s1_wrap ? (s1_ge | s1_le) : (s1_ge & s1_le);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_mask <= '0;
            out_ones <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_mask <= mask_d;
                out_ones <= s1_ones;
            end
        end
    end

endmodule

// File: tb/tb_thermometer_mask_unit.sv
// Directed vector table plus backpressure, mid-flight reset and random soak
// sequences for thermometer_mask_unit, checked against a bit-loop mask model.
module tb_thermometer_mask_unit;
    import thermometer_pkg::*;

    localparam int W = 5;
    localparam int N = 32;
`ifdef THERM_MASK_SKID_EN
    localparam int HELD = 3;
    localparam logic RST_READY = 1'b1;
`else
    localparam int HELD = 2;
    localparam logic RST_READY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    mode_e        in_mode;
    logic [W-1:0] in_lo;
    logic [W-1:0] in_hi;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_mask;
    logic [W:0]   out_ones;

    thermometer_mask_unit #(.InBitWidth(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_lo     (in_lo),
        .in_hi     (in_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_ones  (out_ones)
    );

    always #5 clk = ~clk;

    typedef struct {
        mode_e        mode;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [N-1:0] mask;
        logic [W:0]   ones;
    } vec_t;

    typedef struct {
        logic [N-1:0] mask;
        logic [W:0]   ones;
    } sb_t;

    int  errors = 0;
    int  checks = 0;
    int  delivered = 0;
    sb_t sbq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_mask(input mode_e m, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            case (m)
                THERM_LO: r[k] = (k <= int'(a));
                THERM_HI: r[k] = (k >= int'(a));
                ONEHOT:   r[k] = (k == int'(a));
                default:  r[k] = (a <= b) ? (k >= int'(a) && k <= int'(b))
                                          : (k >= int'(a) || k <= int'(b));
            endcase
        end
        return r;
    endfunction

    // One clock with scoreboard: sample at negedge, return at posedge+1.
    task automatic tick(output bit acc);
        sb_t e;
        @(negedge clk);
        acc = rst_n && in_valid && in_ready;
        if (rst_n && out_valid && out_ready) begin
            delivered++;
            if (sbq.size() == 0) begin
                chk("sb_spurious", out_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("sb_mask", out_mask, e.mask);
                chk("sb_ones", out_ones, e.ones);
                chk("sb_popcnt", $countones(out_mask), out_ones);
            end
        end
        if (acc) begin
            e.mask = model_mask(in_mode, in_lo, in_hi);
            e.ones = (W+1)'($countones(e.mask));
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Single request into an idle pipe; result must appear two edges after acceptance.
    task automatic single(input mode_e m, input logic [W-1:0] lo, input logic [W-1:0] hi,
                          input string tag, output logic [N-1:0] mask, output logic [W:0] ones);
        int lat;
        bit got;
        in_valid  = 1'b1;
        in_mode   = m;
        in_lo     = lo;
        in_hi     = hi;
        out_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got  = 1'b0;
        lat  = 0;
        mask = '0;
        ones = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (out_valid) begin
                got  = 1'b1;
                lat  = i + 1;
                mask = out_mask;
                ones = out_ones;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_lat"}, lat, 2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[13];
        vec_t         bp[6];
        logic [N-1:0] m;
        logic [W:0]   o;
        bit           acc;
        int           idx;
        int           seen;
        int           sent;

        vecs[0]  = '{THERM_LO, 5'd0,  5'd0,  32'h0000_0001, 6'd1};
        vecs[1]  = '{THERM_LO, 5'd31, 5'd0,  32'hFFFF_FFFF, 6'd32};
        vecs[2]  = '{THERM_HI, 5'd28, 5'd0,  32'hF000_0000, 6'd4};
        vecs[3]  = '{THERM_HI, 5'd0,  5'd7,  32'hFFFF_FFFF, 6'd32};
        vecs[4]  = '{ONEHOT,   5'd17, 5'd0,  32'h0002_0000, 6'd1};
        vecs[5]  = '{ONEHOT,   5'd31, 5'd0,  32'h8000_0000, 6'd1};
        vecs[6]  = '{RANGE,    5'd4,  5'd7,  32'h0000_00F0, 6'd4};
        vecs[7]  = '{RANGE,    5'd30, 5'd1,  32'hC000_0003, 6'd4};
        vecs[8]  = '{RANGE,    5'd9,  5'd9,  32'h0000_0200, 6'd1};
        vecs[9]  = '{RANGE,    5'd0,  5'd31, 32'hFFFF_FFFF, 6'd32};
        vecs[10] = '{RANGE,    5'd31, 5'd0,  32'h8000_0001, 6'd2};
        vecs[11] = '{RANGE,    5'd31, 5'd30, 32'hFFFF_FFFF, 6'd32};
        vecs[12] = '{THERM_LO, 5'd15, 5'd3,  32'h0000_FFFF, 6'd16};

        bp[0] = '{THERM_LO, 5'd1,  5'd0,  32'h0, 6'd0};
        bp[1] = '{THERM_HI, 5'd2,  5'd0,  32'h0, 6'd0};
        bp[2] = '{ONEHOT,   5'd3,  5'd0,  32'h0, 6'd0};
        bp[3] = '{RANGE,    5'd5,  5'd20, 32'h0, 6'd0};
        bp[4] = '{RANGE,    5'd25, 5'd2,  32'h0, 6'd0};
        bp[5] = '{THERM_LO, 5'd6,  5'd0,  32'h0, 6'd0};

        // Reset held with a request pending
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_mode   = RANGE;
        in_lo     = 5'd3;
        in_hi     = 5'd12;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_mask", out_mask, 0);
        chk("rst_out_ones", out_ones, 0);
        chk("rst_in_ready", in_ready, RST_READY);
        rst_n = 1'b1;
        single(THERM_LO, 5'd3, 5'd0, "release", m, o);
        chk("release_mask", m, 32'h0000_000F);
        chk("release_ones", o, 4);

        foreach (vecs[i]) begin
            single(vecs[i].mode, vecs[i].lo, vecs[i].hi, $sformatf("vec%0d", i), m, o);
            chk($sformatf("vec%0d_mask", i), m, vecs[i].mask);
            chk($sformatf("vec%0d_ones", i), o, vecs[i].ones);
        end

        // Backpressure: out_ready low during cycles 3..8
        delivered = 0;
        idx = 0;
        for (int c = 1; c <= 40; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                in_mode = bp[idx].mode;
                in_lo   = bp[idx].lo;
                in_hi   = bp[idx].hi;
            end
            out_ready = !(c >= 3 && c <= 8);
            if (c == 8) begin
                #1;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_held", sbq.size(), HELD);
            end
            tick(acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_sent", idx, 6);
        chk("bp_delivered", delivered, 6);
        chk("bp_queue_empty", sbq.size(), 0);

        // Reset with two results in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = ONEHOT;
        in_lo     = 5'd4;
        @(posedge clk);
        #1;
        in_mode = THERM_HI;
        in_lo   = 5'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mid_inflight", out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("mid_no_stale", seen, 0);
        single(THERM_HI, 5'd31, 5'd0, "after_rst", m, o);
        chk("after_rst_mask", m, 32'h8000_0000);
        chk("after_rst_ones", o, 1);

        // Random soak with random backpressure
        sbq.delete();
        delivered = 0;
        sent = 0;
        in_mode = mode_e'($urandom_range(0, 3));
        in_lo   = W'($urandom_range(0, N - 1));
        in_hi   = W'($urandom_range(0, N - 1));
        for (int c = 0; c < 60000 && (sent < 10000 || sbq.size() != 0); c++) begin
            in_valid  = (sent < 10000) && ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) begin
                sent++;
                in_mode = mode_e'($urandom_range(0, 3));
                in_lo   = W'($urandom_range(0, N - 1));
                in_hi   = W'($urandom_range(0, N - 1));
            end
        end
        in_valid = 1'b0;
        chk("soak_sent", sent, 10000);
        chk("soak_delivered", delivered, 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/thermometer_mask_unit.md
# thermometer_mask_unit

Pipelined, parametrised mask generator producing a 2**InBitWidth-bit mask plus its population count from one or two InBitWidth-bit indices. It supports four modes: low thermometer, high thermometer, one-hot, and wrapping range. It sits beside the shifter/store datapath and feeds byte/bit-enable and shift-fill masks. Valid/ready handshakes on both sides let it stall under downstream backpressure without loss.

## Interface
Parameters:
- InBitWidth, 5, index width.
- OutBitWidth, 2**InBitWidth, mask width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit accepts a request this cycle.
- in_mode  in  2  mode_e: THERM_LO=0, THERM_HI=1, ONEHOT=2, RANGE=3.
- in_lo  in  InBitWidth  index a (all modes); range start in RANGE.
- in_hi  in  InBitWidth  range end; used in RANGE only, ignored otherwise.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_mask  out  OutBitWidth  generated mask.
- out_ones  out  InBitWidth+1  number of set bits in out_mask.

## Operation
- Transfer on a side occurs when its valid and ready are both high at a rising edge.
- Mask definitions, for bit k in 0..OutBitWidth-1 and a = in_lo, b = in_hi:
  - THERM_LO: k <= a.
  - THERM_HI: k >= a.
  - ONEHOT: k == a.
  - RANGE with a <= b: a <= k <= b.
  - RANGE with a > b (wrap-around): k >= a or k <= b.
- The mask is never all-zero.
- out_ones uses InBitWidth+1-bit unsigned arithmetic and must not be derived from the mask:
  - THERM_LO: a+1.
  - THERM_HI: OutBitWidth-a.
  - ONEHOT: 1.
  - RANGE with a <= b: b-a+1.
  - RANGE with a > b: OutBitWidth-(a-b)+1.
  - Maximum value is OutBitWidth, hence the extra bit.
- Pipeline:
  - Stage 1 registers mode plus the two thermometer vectors ge_a (k >= a) and le_b (k <= b), where b = a for THERM_LO. It also registers the precomputed count.
  - Stage 2 registers the mask:
    - THERM_LO: le_b.
    - THERM_HI: ge_a.
    - ONEHOT: ge_a & le_a.
    - RANGE: ge_a & le_b when a <= b, else ge_a | le_b.
- Each stage holds a valid bit. A stage loads when it is empty or its contents move downstream in the same cycle. A stalled stage holds its data unchanged.
- Reset values: out_valid=0, out_mask=0, out_ones=0, both stage valid bits 0. in_ready=1 (0 while rst_n is low).
- Reset mid-operation discards all in-flight results. No out_valid is raised for them after reset.

## Timing
- Latency: a request accepted at edge N presents out_valid=1 with its result after edge N+2.
- Throughput: one result per cycle while out_ready=1.
- in_ready = !s1_valid || s1_advance. s1_advance = !s2_valid || out_ready.
- Full pipeline with out_ready=0: in_ready=0, and out_* stays stable until consumed.
- A simultaneous accept and drain in the same cycle is legal and loses no bubble.
- Results are delivered in acceptance order, exactly once.

## Configuration
- THERM_MASK_SKID_EN defined:
  - A one-entry skid buffer sits ahead of stage 1.
  - in_ready is driven from a flop, equal to "skid empty", with no combinational path from out_ready.
  - A request accepted while stage 1 stalls lands in the skid buffer. It enters stage 1 before any new request, adding one cycle of latency for that request.
  - in_ready resets to 1.
- THERM_MASK_SKID_EN undefined: no skid buffer; in_ready is combinational as above.
- Ordering and exactly-once delivery are identical in both builds.

## Structure
- Package thermometer_pkg:
  - mode_e enum (2 bits).
  - Localparam helpers for OutBitWidth.
  - Function thermo_count(mode, a, b) returning InBitWidth+1 bits.
- Sub-module thermometer_ge_decode: combinational InBitWidth-to-OutBitWidth "k >= a" decoder.
  - Instantiated twice: once for a; once for b+1, with the result inverted to give le_b.
  - When b is all-ones, b+1 wraps to 0, so le_b must be forced to all-ones.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles with in_valid=1. Required: out_valid=0, out_mask=0, out_ones=0. The first result appears 2 cycles after release.
- THERM_LO edges: a=0 -> mask 0x00000001, ones=1. a=31 -> mask 0xFFFFFFFF, ones=32. THERM_HI a=28 -> 0xF0000000, ones=4.
- ONEHOT and RANGE: ONEHOT a=17 -> 0x00020000, ones=1. RANGE lo=4, hi=7 -> 0x000000F0, ones=4. RANGE lo=30, hi=1 (wrap) -> 0xC0000003, ones=4. RANGE lo=hi=9 -> 0x00000200, ones=1.
- Backpressure: 6 back-to-back requests with out_ready=0 for cycles 3-8. Required: in_ready drops once full (2 held; 3 with skid). All 6 results are delivered in order with no duplicates.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 2 results in flight. Required: neither is ever presented, and the next request returns after 2 cycles.
- Random soak: 10k random mode/lo/hi with random out_ready. Scoreboard the mask against the bit-loop model and require popcount(mask)==out_ones. Run with and without THERM_MASK_SKID_EN.
